// File: rtl/decode_uop_sequencer_pkg.sv
// Shared definitions for the register-list micro-op sequencer.
//   list_op_t   : decoded list operation (none / push / pop)
//   seq_state_t : sequencer FSM states
//   LR_ADDR / PC_ADDR : default registers added by the push / pop extra bit
//   WORD_BYTES  : stride between consecutive stack slots
package decode_uop_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2
    } list_op_t;

    typedef enum logic {
        SEQ_IDLE  = 1'b0,
        SEQ_ISSUE = 1'b1
    } seq_state_t;

    localparam int LR_ADDR    = 14;
    localparam int PC_ADDR    = 15;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/decode_uop_sequencer_lowest_set_bit_finder.sv
// Combinational lowest-set-bit finder.
//   vec_i : input vector (W bits)
//   idx_o : index of the lowest set bit (0 when none set)
//   any_o : 1 when at least one bit of vec_i is set
module lowest_set_bit_finder #(
    parameter  int W  = 9,
    localparam int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Scan from the top so the last hit, i.e. the lowest index, wins.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IW'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decode_uop_sequencer.sv
// Expands a decoded PUSH/POP register-list instruction into one single-register
// memory micro-op per cycle, with a registered single-entry output stage.
// Optional feature macro: UOP_SEQ_PERF_CNT_EN adds stall_count_o.
// Ports:
//   clk_i, reset_n_i          : clock, async active-low reset
//   flush_i                   : synchronous flush, highest priority
//   in_valid_i / in_ready_o   : instruction handshake
//   list_op_i, reg_list_i, extra_i, single_reg_i, sp_i : decoded instruction
//   out_valid_o / out_ready_i : micro-op handshake
//   uop_reg_addr_o, uop_mem_addr_o, uop_is_store_o, uop_last_o : micro-op
//   sp_wb_valid_o, sp_wb_data_o : one-shot stack-pointer writeback
//   stall_count_o (optional)  : saturating count of output stall cycles
module decode_uop_sequencer
    import decode_uop_sequencer_pkg::*;
#(
    parameter int WORD            = 32,
    parameter int ADDR_WIDTH      = 4,
    parameter int LIST_W          = 8,
    parameter int PUSH_EXTRA_ADDR = LR_ADDR,
    parameter int POP_EXTRA_ADDR  = PC_ADDR
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  list_op_t              list_op_i,
    input  logic [LIST_W-1:0]     reg_list_i,
    input  logic                  extra_i,
    input  logic [ADDR_WIDTH-1:0] single_reg_i,
    input  logic [WORD-1:0]       sp_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH-1:0] uop_reg_addr_o,
    output logic [WORD-1:0]       uop_mem_addr_o,
    output logic                  uop_is_store_o,
    output logic                  uop_last_o,
    output logic                  sp_wb_valid_o,
    output logic [WORD-1:0]       sp_wb_data_o
`ifdef UOP_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]           stall_count_o
`endif
);

    // Mask bit LIST_W holds the extra register so it naturally issues last.
    localparam int MW = LIST_W + 1;
    localparam int IW = (MW > 1) ? $clog2(MW) : 1;
    localparam int CW = $clog2(LIST_W + 2);

    seq_state_t            state_q, state_d;
    logic [MW-1:0]         mask_q, mask_d;
    logic [WORD-1:0]       base_q, base_d;
    logic [WORD-1:0]       newsp_q, newsp_d;
    logic                  push_q, push_d;
    logic                  out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0] reg_q, reg_d;
    logic [WORD-1:0]       mem_q, mem_d;
    logic                  store_q, store_d;
    logic                  last_q, last_d;
    logic                  wb_q, wb_d;

    logic [MW-1:0]         in_mask, cur_mask, rest_mask;
    logic [CW-1:0]         n_in;
    logic [WORD-1:0]       off, in_base, in_newsp, cur_base;
    logic                  in_push, cur_push, sel_issue, load_ok, accept;
    logic [IW-1:0]         lsb_idx;
    logic                  lsb_any;
    logic [ADDR_WIDTH-1:0] cur_reg;

    assign in_mask = {extra_i, reg_list_i};

    always_comb begin
        n_in = '0;
        for (int i = 0; i < MW; i++) n_in = n_in + CW'(in_mask[i]);
    end

    assign off      = WORD'(n_in) * WORD'(WORD_BYTES);
    assign in_push  = (list_op_i == OP_PUSH);
    assign in_base  = in_push ? sp_i - off : sp_i;
    assign in_newsp = in_push ? sp_i - off : sp_i + off;

    // The first micro-op is formed straight from the incoming instruction so it
    // appears the cycle after acceptance; later ones come from the held mask.
    assign sel_issue = (state_q == SEQ_ISSUE);
    assign cur_mask  = sel_issue ? mask_q : in_mask;
    assign cur_base  = sel_issue ? base_q : in_base;
    assign cur_push  = sel_issue ? push_q : in_push;

    lowest_set_bit_finder #(.W(MW)) u_lsb (
        .vec_i (cur_mask),
        .idx_o (lsb_idx),
        .any_o (lsb_any)
    );

    assign rest_mask = cur_mask & ~(MW'(1) << lsb_idx);
    assign cur_reg   = (lsb_idx == IW'(LIST_W))
                     ? (cur_push ? ADDR_WIDTH'(PUSH_EXTRA_ADDR) : ADDR_WIDTH'(POP_EXTRA_ADDR))
                     : ADDR_WIDTH'(lsb_idx);

    assign load_ok    = !out_valid_q || out_ready_i;
    assign in_ready_o = reset_n_i && !sel_issue && !flush_i && load_ok;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        base_d      = base_q;
        newsp_d     = newsp_q;
        push_d      = push_q;
        out_valid_d = out_valid_q;
        reg_d       = reg_q;
        mem_d       = mem_q;
        store_d     = store_q;
        last_d      = last_q;
        wb_d        = wb_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
            mask_d      = '0;
            state_d     = SEQ_IDLE;
        end else begin
            if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
            if (accept && list_op_i == OP_NONE) begin
                out_valid_d = 1'b1;
                reg_d       = single_reg_i;
                mem_d       = sp_i;
                store_d     = 1'b0;
                last_d      = 1'b1;
                wb_d        = 1'b0;
            end else if ((accept || (sel_issue && load_ok)) && lsb_any) begin
                out_valid_d = 1'b1;
                reg_d       = cur_reg;
                mem_d       = cur_base;
                store_d     = cur_push;
                last_d      = (rest_mask == '0);
                wb_d        = 1'b1;
                mask_d      = rest_mask;
                base_d      = cur_base + WORD'(WORD_BYTES);
                state_d     = (rest_mask == '0) ? SEQ_IDLE : SEQ_ISSUE;
                if (!sel_issue) begin
                    push_d  = in_push;
                    newsp_d = in_newsp;
                end
            end
            // An accepted empty list falls through: nothing issued, no writeback.
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= SEQ_IDLE;
            mask_q      <= '0;
            base_q      <= '0;
            newsp_q     <= '0;
            push_q      <= 1'b0;
            out_valid_q <= 1'b0;
            reg_q       <= '0;
            mem_q       <= '0;
            store_q     <= 1'b0;
            last_q      <= 1'b0;
            wb_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            base_q      <= base_d;
            newsp_q     <= newsp_d;
            push_q      <= push_d;
            out_valid_q <= out_valid_d;
            reg_q       <= reg_d;
            mem_q       <= mem_d;
            store_q     <= store_d;
            last_q      <= last_d;
            wb_q        <= wb_d;
        end
    end

    assign out_valid_o    = out_valid_q;
    assign uop_reg_addr_o = reg_q;
    assign uop_mem_addr_o = mem_q;
    assign uop_is_store_o = store_q;
    assign uop_last_o     = last_q;
    // A flushed handshake of the last micro-op must not commit the new SP.
    assign sp_wb_valid_o  = out_valid_q && out_ready_i && last_q && wb_q && !flush_i;
    assign sp_wb_data_o   = newsp_q;

`ifdef UOP_SEQ_PERF_CNT_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)                                          stall_q <= '0;
        else if (out_valid_q && !out_ready_i && stall_q != '1)   stall_q <= stall_q + 32'd1;
    end
    assign stall_count_o = stall_q;
`endif

endmodule

// File: tb/tb_decode_uop_sequencer.sv
module tb_decode_uop_sequencer;
    import decode_uop_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    list_op_t    list_op = OP_NONE;
    logic [7:0]  reg_list = '0;
    logic        extra = 1'b0;
    logic [3:0]  single_reg = '0;
    logic [31:0] sp = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  uop_reg;
    logic [31:0] uop_mem;
    logic        uop_store;
    logic        uop_last;
    logic        sp_wb_valid;
    logic [31:0] sp_wb_data;
`ifdef UOP_SEQ_PERF_CNT_EN
    logic [31:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_uop_sequencer dut (
        .clk_i          (clk),
        .reset_n_i      (rst_n),
        .flush_i        (flush),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .list_op_i      (list_op),
        .reg_list_i     (reg_list),
        .extra_i        (extra),
        .single_reg_i   (single_reg),
        .sp_i           (sp),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .uop_reg_addr_o (uop_reg),
        .uop_mem_addr_o (uop_mem),
        .uop_is_store_o (uop_store),
        .uop_last_o     (uop_last),
        .sp_wb_valid_o  (sp_wb_valid),
        .sp_wb_data_o   (sp_wb_data)
`ifdef UOP_SEQ_PERF_CNT_EN
        ,
        .stall_count_o  (stall_count)
`endif
    );

    // mode 0: always ready, 1: alternating 1,0,1,0..., 2: random (mostly ready)
    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 2) == 0;
        return $urandom_range(0, 3) != 0;
    endfunction

    // Drives one instruction and follows its micro-ops against a reference
    // expansion computed from the list semantics: ascending registers, extra
    // register last, slot k at base + 4k, SP moved by 4 bytes per register.
    task automatic run_seq(input string name, input list_op_t op, input logic [7:0] lst,
                           input logic ext, input logic [3:0] sreg,
                           input logic [31:0] spv, input int mode);
        int          exp_reg[$];
        logic [31:0] base, nsp, exp_addr;
        logic        exp_wb, exp_store, rdy, exp_sp_wb, exp_in_rdy;
        int          n, idx, wbs, cyc;
        nsp = 32'h0;
        if (op == OP_NONE) begin
            exp_reg.push_back(int'(sreg));
            base = spv; exp_wb = 1'b0; exp_store = 1'b0;
        end else begin
            for (int k = 0; k < 8; k++) if (lst[k]) exp_reg.push_back(k);
            if (ext) exp_reg.push_back(op == OP_PUSH ? 14 : 15);
            n = exp_reg.size();
            base = (op == OP_PUSH) ? spv - 32'(4 * n) : spv;
            nsp  = (op == OP_PUSH) ? spv - 32'(4 * n) : spv + 32'(4 * n);
            exp_wb = (n > 0); exp_store = (op == OP_PUSH);
        end
        in_valid = 1'b1; list_op = op; reg_list = lst; extra = ext;
        single_reg = sreg; sp = spv; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s accept: in_ready=%b expected 1", name, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; reg_list = 8'($urandom); sp = $urandom;
        idx = 0; wbs = 0; cyc = 0;
        while (idx < exp_reg.size() && cyc < 200) begin
            rdy = ready_for(mode, cyc);
            out_ready = rdy;
            #1;
            exp_addr   = base + 32'(4 * idx);
            exp_sp_wb  = rdy && exp_wb && (idx == exp_reg.size() - 1);
            exp_in_rdy = rdy && (idx == exp_reg.size() - 1);
            checks++;
            if ({out_valid, uop_reg, uop_mem, uop_store, uop_last} !==
                {1'b1, 4'(exp_reg[idx]), exp_addr, exp_store, idx == exp_reg.size() - 1}) begin
                errors++;
                $display("FAIL %s uop%0d: got v=%b r=%0d a=%h s=%b l=%b expected v=1 r=%0d a=%h s=%b l=%b",
                         name, idx, out_valid, uop_reg, uop_mem, uop_store, uop_last,
                         exp_reg[idx], exp_addr, exp_store, idx == exp_reg.size() - 1);
            end
            checks++;
            if (sp_wb_valid !== exp_sp_wb) begin
                errors++; $display("FAIL %s sp_wb_valid uop%0d: got %b expected %b", name, idx, sp_wb_valid, exp_sp_wb);
            end
            checks++;
            if (in_ready !== exp_in_rdy) begin
                errors++; $display("FAIL %s in_ready uop%0d: got %b expected %b", name, idx, in_ready, exp_in_rdy);
            end
            if (sp_wb_valid === 1'b1) begin
                wbs++;
                checks++;
                if (sp_wb_data !== nsp) begin
                    errors++; $display("FAIL %s sp_wb_data: got %h expected %h", name, sp_wb_data, nsp);
                end
            end
            if (rdy) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin
            errors++; $display("FAIL %s timeout: issued %0d expected %0d", name, idx, exp_reg.size());
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, sp_wb_valid} !== 3'b010) begin
            errors++; $display("FAIL %s drained: v/in_ready/wb=%b%b%b expected 010", name, out_valid, in_ready, sp_wb_valid);
        end
        checks++;
        if (wbs != (exp_wb ? 1 : 0)) begin
            errors++; $display("FAIL %s sp_wb count: got %0d expected %0d", name, wbs, exp_wb ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({out_valid, in_ready, uop_reg, uop_mem, uop_store, uop_last, sp_wb_valid, sp_wb_data} !== '0) begin
            errors++; $display("FAIL reset outputs: v=%b rdy=%b r=%0d a=%h expected all 0", out_valid, in_ready, uop_reg, uop_mem);
        end
        @(posedge clk); #2; rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++; $display("FAIL reset release: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
    endtask

`ifdef UOP_SEQ_PERF_CNT_EN
    task automatic test_perf_cnt();
        checks++;
        if (stall_count !== 32'd0) begin
            errors++; $display("FAIL stall_count reset: got %0d expected 0", stall_count);
        end
        in_valid = 1'b1; list_op = OP_PUSH; reg_list = 8'h01; extra = 1'b0; sp = 32'h80; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            out_ready = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (stall_count !== 32'd5) begin
            errors++; $display("FAIL stall_count: got %0d expected 5", stall_count);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_push_lr();
        run_seq("push_lr", OP_PUSH, 8'b0000_0101, 1'b1, 4'd0, 32'h100, 0);
    endtask

    task automatic test_pop_pc_toggle();
        run_seq("pop_pc", OP_POP, 8'b1000_0010, 1'b1, 4'd0, 32'h200, 1);
    endtask

    task automatic test_full_wrap();
        run_seq("full_wrap", OP_PUSH, 8'hFF, 1'b1, 4'd0, 32'h20, 0);
    endtask

    task automatic test_flush();
        in_valid = 1'b1; list_op = OP_POP; reg_list = 8'h07; extra = 1'b0; sp = 32'h300; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        #1;
        checks++;
        if ({out_valid, uop_reg, uop_mem, in_ready, sp_wb_valid} !== {1'b1, 4'd1, 32'h304, 1'b0, 1'b0}) begin
            errors++; $display("FAIL flush same-cycle: v=%b r=%0d a=%h rdy=%b wb=%b expected 1 1 304 0 0",
                               out_valid, uop_reg, uop_mem, in_ready, sp_wb_valid);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++;
            if ({out_valid, in_ready, sp_wb_valid} !== 3'b010) begin
                errors++; $display("FAIL flush after %0d: v/rdy/wb=%b%b%b expected 010", j, out_valid, in_ready, sp_wb_valid);
            end
            @(posedge clk); #1;
        end
        run_seq("none_after_flush", OP_NONE, 8'h00, 1'b0, 4'd5, 32'h1234, 0);
        // Flush coinciding with the handshake of the last micro-op.
        in_valid = 1'b1; list_op = OP_PUSH; reg_list = 8'h08; extra = 1'b0; sp = 32'h40; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b1;
        #1;
        checks++;
        if ({out_valid, uop_last, sp_wb_valid} !== 3'b110) begin
            errors++; $display("FAIL flush last: v/last/wb=%b%b%b expected 110", out_valid, uop_last, sp_wb_valid);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        checks++;
        if ({out_valid, sp_wb_valid} !== 2'b00) begin
            errors++; $display("FAIL flush last after: v/wb=%b%b expected 00", out_valid, sp_wb_valid);
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; list_op = OP_PUSH; reg_list = 8'hFF; extra = 1'b1; sp = 32'h1000; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, uop_reg, uop_mem, uop_store, uop_last, sp_wb_valid, sp_wb_data} !== '0) begin
            errors++; $display("FAIL async reset: v=%b rdy=%b r=%0d a=%h st=%b wb=%b expected all 0",
                               out_valid, in_ready, uop_reg, uop_mem, uop_store, sp_wb_valid);
        end
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid, sp_wb_valid} !== 3'b100) begin
            errors++; $display("FAIL reset release2: rdy/v/wb=%b%b%b expected 100", in_ready, out_valid, sp_wb_valid);
        end
        run_seq("empty_list", OP_PUSH, 8'h00, 1'b0, 4'd0, 32'h500, 0);
    endtask

    task automatic test_random();
        list_op_t op;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 2))
                0:       op = OP_NONE;
                1:       op = OP_PUSH;
                default: op = OP_POP;
            endcase
            run_seq($sformatf("rand%0d", t), op, 8'($urandom), 1'($urandom), 4'($urandom),
                    $urandom, 2);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef UOP_SEQ_PERF_CNT_EN
        test_perf_cnt();
`endif
        test_push_lr();
        test_pop_pc_toggle();
        test_full_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_uop_sequencer.md
Name: decode_uop_sequencer

Overview:
Parametrised successor to the decode-stage multi-cycle control. It expands a decoded register-list instruction (PUSH/POP, generalised to LIST_W list bits) into one single-register memory micro-op per cycle. The block sits between the instruction decoder and the decode/execute register. It has a valid/ready handshake on both sides, a registered single-entry output, flush support, and a one-shot stack-pointer writeback on the last micro-op.

Parameters:
WORD, 32, data/address width
ADDR_WIDTH, 4, register address width
LIST_W, 8, register-list width; bit k selects register k (LIST_W <= 2**ADDR_WIDTH - 2)
PUSH_EXTRA_ADDR, 14, register added by the push extra bit (LR)
POP_EXTRA_ADDR, 15, register added by the pop extra bit (PC)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
flush_i  in  1  synchronous pipeline flush
in_valid_i  in  1  decoded instruction valid
in_ready_o  out  1  sequencer can accept an instruction
list_op_i  in  2  list_op_t: OP_NONE/OP_PUSH/OP_POP
reg_list_i  in  LIST_W  register list
extra_i  in  1  include PUSH_EXTRA_ADDR (push) or POP_EXTRA_ADDR (pop)
single_reg_i  in  ADDR_WIDTH  register for OP_NONE passthrough
sp_i  in  WORD  current stack pointer
out_valid_o  out  1  micro-op valid
out_ready_i  in  1  downstream accepts micro-op
uop_reg_addr_o  out  ADDR_WIDTH  register for this micro-op
uop_mem_addr_o  out  WORD  memory address for this micro-op
uop_is_store_o  out  1  1 = store (push), 0 = load (pop) or passthrough
uop_last_o  out  1  final micro-op of the instruction
sp_wb_valid_o  out  1  one-cycle pulse: write sp_wb_data_o to SP
sp_wb_data_o  out  WORD  new stack pointer

Behaviour:
- Reset (async, reset_n_i low): state IDLE. All outputs 0, except in_ready_o = 1 once reset is deasserted.
- States:
  - IDLE: in_ready_o = !flush_i && (!out_valid_o || out_ready_i).
  - ISSUE: in_ready_o = 0.
- Accepting an instruction (in_valid_i && in_ready_o):
  - Capture the remaining mask = reg_list_i plus the extra bit.
  - Capture n = popcount, with width $clog2(LIST_W+2).
  - Capture base: push base = sp_i - 4*n; pop base = sp_i.
  - Capture new SP: push = sp_i - 4*n; pop = sp_i + 4*n.
- Latency: first micro-op has out_valid_o in the cycle after acceptance. Throughput is 1 micro-op/cycle while out_ready_i = 1.
- Issue order:
  - Registers issue in ascending order; the extra register issues last.
  - Micro-op k (0-based) has uop_mem_addr_o = base + 4*k.
  - The issued bit is cleared from the mask when the output register loads.
- Output register holds while out_valid_o && !out_ready_i. It reloads when empty or on a handshake.
- uop_last_o = 1 on the micro-op that empties the mask. The FSM returns to IDLE when that micro-op loads.
- sp_wb_valid_o pulses for exactly one cycle, in the cycle the last push/pop micro-op handshakes (out_valid_o && out_ready_i && uop_last_o).
- OP_NONE: a single micro-op with uop_reg_addr_o = single_reg_i, uop_mem_addr_o = sp_i, uop_is_store_o = 0, uop_last_o = 1. No SP writeback; the FSM stays in IDLE.
- n = 0 (empty list, extra_i = 0): accepted, no micro-op emitted, no SP writeback, stays IDLE.
- Full range: LIST_W ones plus extra yields LIST_W+1 micro-ops with no counter overflow.
- Address arithmetic wraps modulo 2**WORD.
- flush_i:
  - Highest priority.
  - Next edge: out_valid_o = 0, mask cleared, state IDLE, no sp_wb pulse.
  - A same-cycle input is not accepted.
  - A same-cycle handshake of the last micro-op is discarded; no sp_wb.
- Reset mid-sequence: abandons the sequence immediately, with no writeback.

Optional Feature:
UOP_SEQ_PERF_CNT_EN:
- Defined: adds output stall_count_o [31:0]. It counts cycles with out_valid_o && !out_ready_i, saturates at 32'hFFFF_FFFF, and clears on reset only.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (GENERAL_DEFS):
  - list_op_t enum.
  - seq_state_t {SEQ_IDLE, SEQ_ISSUE}.
  - LR_ADDR = 14, PC_ADDR = 15.
  - WORD_BYTES = 4.
- Sub-module lowest_set_bit_finder (parameter W): combinational. Outputs the index of the lowest set bit and an any-set flag. Used to select the next register from the mask.

Test Plan:
- PUSH {r0,r2}+LR, sp_i = 0x100, out_ready_i = 1: micro-ops (r0, 0xF4), (r2, 0xF8), (r14, 0xFC, last), all store. sp_wb pulse with data 0xF4 on the third handshake.
- POP {r1,r7}+PC, sp_i = 0x200, out_ready_i toggling 1,0,1,0: loads (r1, 0x200), (r7, 0x204), (r15, 0x208, last). Each micro-op holds stable while ready = 0. sp_wb = 0x20C exactly once.
- PUSH of all 8 list bits + LR, sp_i = 0x20: 9 micro-ops, addresses 0xFFFF_FFFC through 0x1C (wrap). in_ready_o = 0 throughout; sp_wb = 0xFFFF_FFFC.
- flush_i on the 2nd micro-op of POP {r0,r1,r2}: out_valid_o = 0 next cycle, no sp_wb, in_ready_o = 1. A following OP_NONE r5 is issued as a single micro-op marked last.
- reset_n_i low mid-push, asynchronously between edges: outputs drop to 0 immediately. After release, in_ready_o = 1. An empty list is then accepted with no micro-op and no sp_wb.
- With UOP_SEQ_PERF_CNT_EN defined: hold out_ready_i = 0 for 5 cycles with a valid micro-op, so stall_count_o = 5.
